// File: rtl/pe_psum_accum.sv
// PE partial-sum receiver: recombines MAC tap sums by precision, accumulates beats, buffers results.
// Optional PSUM_SAT_EN macro: saturating accumulate instead of two's-complement wrap.
module pe_psum_accum #(
    parameter int unsigned ACC_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [127:0]         mac_out_data,
    input  logic                 mac_out_valid,
    input  logic [1:0]           mac_cfg_conv_mode,
    input  logic [1:0]           mac_cfg_preci,
    input  logic [7:0]           acc_len,
    input  logic                 clr,
    output logic [8*ACC_W-1:0]   psum_out_data,
    output logic                 psum_out_valid,
    input  logic                 psum_out_ready,
    output logic                 busy,
    output logic                 err_overflow
);
    localparam int unsigned TAPS  = 8;
    localparam int unsigned TAP_W = 16;
    localparam int unsigned LANES = 8;

    typedef enum logic [0:0] {IDLE, ACCUM} state_e;

    state_e                         state_q, state_d;
    logic [1:0]                     preci_q, preci_d;
    logic [1:0]                     mode_q, mode_d;
    logic [7:0]                     len_q, len_d;
    logic [7:0]                     beat_cnt_q, beat_cnt_d;
    logic [LANES-1:0][ACC_W-1:0]    comb_q, comb_d;
    logic                           comb_vld_q, comb_vld_d;
    logic                           comb_last_q, comb_last_d;
    logic [LANES-1:0][ACC_W-1:0]    acc_q, acc_d;
    logic [LANES-1:0][ACC_W-1:0]    out_q, out_d;
    logic                           out_vld_q, out_vld_d;
    logic                           busy_q, busy_d;
    logic                           err_q, err_d;

    logic [TAPS-1:0][ACC_W-1:0]     tap;
    logic [3:0][ACC_W-1:0]          p;
    logic [LANES-1:0][ACC_W-1:0]    lane;
    logic [LANES-1:0][ACC_W-1:0]    sum;
    logic [1:0]                     sel_preci;
    logic [1:0]                     sel_mode;
    logic                           beat;
    logic                           last;

`ifdef PSUM_SAT_EN
    function automatic logic [ACC_W-1:0] add_lane(input logic [ACC_W-1:0] a, input logic [ACC_W-1:0] b);
        logic [ACC_W:0] s;
        s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        if (s[ACC_W] != s[ACC_W-1])
            return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        return s[ACC_W-1:0];
    endfunction
`else
    function automatic logic [ACC_W-1:0] add_lane(input logic [ACC_W-1:0] a, input logic [ACC_W-1:0] b);
        return ACC_W'(a + b);
    endfunction
`endif

    // Lane recombination; the first beat of a group uses the live config it is latching.
    always_comb begin
        sel_preci = (state_q == IDLE) ? mac_cfg_preci : preci_q;
        sel_mode  = (state_q == IDLE) ? mac_cfg_conv_mode : mode_q;
        for (int k = 0; k < TAPS; k++)
            tap[k] = ACC_W'($signed(mac_out_data[TAP_W*k +: TAP_W]));
        for (int k = 0; k < 4; k++)
            p[k] = ACC_W'(tap[k] + (tap[k+4] << 4));
        lane = '0;
        if (sel_mode == 2'b00 || sel_preci == 2'b00) begin
            lane = tap;
        end else begin
            case (sel_preci)
                2'b01: begin
                    for (int k = 0; k < 4; k++) lane[k] = p[k];
                end
                2'b10: begin
                    lane[0] = ACC_W'((p[0] << 8) + p[1]);
                    lane[1] = ACC_W'((p[2] << 8) + p[3]);
                end
                default: begin
                    lane[0] = ACC_W'((((p[0] << 8) + p[1]) << 8) + (p[2] << 8) + p[3]);
                end
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        preci_d     = preci_q;
        mode_d      = mode_q;
        len_d       = len_q;
        beat_cnt_d  = beat_cnt_q;
        comb_d      = comb_q;
        comb_vld_d  = 1'b0;
        comb_last_d = 1'b0;
        acc_d       = acc_q;
        out_d       = out_q;
        out_vld_d   = out_vld_q;
        err_d       = err_q;
        sum         = '0;
        last        = 1'b0;
        beat        = mac_out_valid && !clr;

        case (state_q)
            IDLE: begin
                if (beat) begin
                    preci_d    = mac_cfg_preci;
                    mode_d     = mac_cfg_conv_mode;
                    len_d      = acc_len;
                    beat_cnt_d = 8'd1;
                    if (acc_len <= 8'd1) last = 1'b1;
                    else                 state_d = ACCUM;
                end
            end
            default: begin
                if (beat) begin
                    beat_cnt_d = 8'(beat_cnt_q + 8'd1);
                    if (beat_cnt_d == len_q) begin
                        last    = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
        endcase

        comb_vld_d  = beat;
        comb_last_d = last;
        if (beat) comb_d = lane;

        if (out_vld_q && psum_out_ready) out_vld_d = 1'b0;

        // A load in the same cycle as an accept replaces the buffer and keeps valid high.
        if (comb_vld_q && !clr) begin
            for (int n = 0; n < LANES; n++) sum[n] = add_lane(acc_q[n], comb_q[n]);
            if (comb_last_q) begin
                acc_d = '0;
                if (!out_vld_q || psum_out_ready) begin
                    out_d     = sum;
                    out_vld_d = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end else begin
                acc_d = sum;
            end
        end

        if (clr) begin
            state_d     = IDLE;
            beat_cnt_d  = '0;
            acc_d       = '0;
            comb_vld_d  = 1'b0;
            comb_last_d = 1'b0;
            err_d       = 1'b0;
        end
    end

    assign busy_d = (state_d == ACCUM) || comb_vld_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            preci_q     <= '0;
            mode_q      <= '0;
            len_q       <= '0;
            beat_cnt_q  <= '0;
            comb_q      <= '0;
            comb_vld_q  <= 1'b0;
            comb_last_q <= 1'b0;
            acc_q       <= '0;
            out_q       <= '0;
            out_vld_q   <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            preci_q     <= preci_d;
            mode_q      <= mode_d;
            len_q       <= len_d;
            beat_cnt_q  <= beat_cnt_d;
            comb_q      <= comb_d;
            comb_vld_q  <= comb_vld_d;
            comb_last_q <= comb_last_d;
            acc_q       <= acc_d;
            out_q       <= out_d;
            out_vld_q   <= out_vld_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    assign psum_out_data  = out_q;
    assign psum_out_valid = out_vld_q;
    assign busy           = busy_q;
    assign err_overflow   = err_q;

endmodule

// File: tb/tb_pe_psum_accum.sv
// Directed bench for pe_psum_accum (ACC_W = 32); expectations hand-computed from the lane rules.
module tb_pe_psum_accum;
    localparam int unsigned ACC_W = 32;

    logic                clk = 1'b0;
    logic                rst;
    logic [127:0]        mac_out_data;
    logic                mac_out_valid;
    logic [1:0]          mac_cfg_conv_mode;
    logic [1:0]          mac_cfg_preci;
    logic [7:0]          acc_len;
    logic                clr;
    logic [8*ACC_W-1:0]  psum_out_data;
    logic                psum_out_valid;
    logic                psum_out_ready;
    logic                busy;
    logic                err_overflow;

    int n_chk  = 0;
    int n_pass = 0;

    pe_psum_accum #(.ACC_W(ACC_W)) dut (
        .clk               (clk),
        .rst               (rst),
        .mac_out_data      (mac_out_data),
        .mac_out_valid     (mac_out_valid),
        .mac_cfg_conv_mode (mac_cfg_conv_mode),
        .mac_cfg_preci     (mac_cfg_preci),
        .acc_len           (acc_len),
        .clr               (clr),
        .psum_out_data     (psum_out_data),
        .psum_out_valid    (psum_out_valid),
        .psum_out_ready    (psum_out_ready),
        .busy              (busy),
        .err_overflow      (err_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [127:0] tp(input logic [15:0] t0, t1, t2, t3, t4, t5, t6, t7);
        return {t7, t6, t5, t4, t3, t2, t1, t0};
    endfunction

    function automatic logic [255:0] ln(input logic [31:0] l0, l1, l2, l3, l4, l5, l6, l7);
        return {l7, l6, l5, l4, l3, l2, l1, l0};
    endfunction

    // Present d for n consecutive beats; returns at the negedge after the last capturing edge.
    task automatic beats(input logic [127:0] d, input int n);
        mac_out_data  = d;
        mac_out_valid = 1'b1;
        repeat (n) @(negedge clk);
        mac_out_valid = 1'b0;
    endtask

    task automatic cfg(input logic [1:0] mode, input logic [1:0] preci, input logic [7:0] len);
        mac_cfg_conv_mode = mode;
        mac_cfg_preci     = preci;
        acc_len           = len;
    endtask

    initial begin
        logic [31:0] sat_exp;
        rst = 1'b1; mac_out_data = '0; mac_out_valid = 1'b0; clr = 1'b0;
        psum_out_ready = 1'b0;
        cfg(2'b01, 2'b00, 8'd1);
        repeat (2) @(negedge clk);
        chk("rst_data",  psum_out_data, '0);
        chk("rst_valid", 256'(psum_out_valid), 256'(0));
        chk("rst_busy",  256'(busy), 256'(0));
        chk("rst_err",   256'(err_overflow), 256'(0));
        rst = 1'b0;
        psum_out_ready = 1'b1;
        @(negedge clk);

        // preci 00, single beat: lanes are the raw taps
        beats(tp(1, 2, 3, 4, 5, 6, 7, 8), 1);
        chk("t1_valid_early", 256'(psum_out_valid), 256'(0));
        chk("t1_busy",        256'(busy), 256'(1));
        @(negedge clk);
        chk("t1_valid", 256'(psum_out_valid), 256'(1));
        chk("t1_data",  psum_out_data, ln(1, 2, 3, 4, 5, 6, 7, 8));
        chk("t1_busy_done", 256'(busy), 256'(0));
        @(negedge clk);
        chk("t1_valid_drop", 256'(psum_out_valid), 256'(0));

        // preci 01, three beats of -1 + (2<<4) = 31
        cfg(2'b01, 2'b01, 8'd3);
        beats(tp(16'hFFFF, 0, 0, 0, 16'h0002, 0, 0, 0), 3);
        chk("t2_valid_early", 256'(psum_out_valid), 256'(0));
        @(negedge clk);
        chk("t2_valid", 256'(psum_out_valid), 256'(1));
        chk("t2_data",  psum_out_data, ln(93, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        chk("t2_valid_once", 256'(psum_out_valid), 256'(0));

        // preci 11, back-to-back single-beat groups
        cfg(2'b01, 2'b11, 8'd1);
        mac_out_data = tp(1, 0, 0, 0, 0, 0, 0, 0); mac_out_valid = 1'b1;
        @(negedge clk);
        mac_out_data = tp(0, 0, 0, 5, 0, 0, 0, 0);
        @(negedge clk);
        mac_out_valid = 1'b0;
        chk("t3_valid_a", 256'(psum_out_valid), 256'(1));
        chk("t3_data_a",  psum_out_data, ln(65536, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        chk("t3_valid_b", 256'(psum_out_valid), 256'(1));
        chk("t3_data_b",  psum_out_data, ln(5, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        chk("t3_valid_drop", 256'(psum_out_valid), 256'(0));

        // overflow: full buffer keeps 7, drops 9
        psum_out_ready = 1'b0;
        cfg(2'b01, 2'b00, 8'd1);
        mac_out_data = tp(7, 0, 0, 0, 0, 0, 0, 0); mac_out_valid = 1'b1;
        @(negedge clk);
        mac_out_data = tp(9, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        mac_out_valid = 1'b0;
        @(negedge clk);
        chk("t4_data", psum_out_data, ln(7, 0, 0, 0, 0, 0, 0, 0));
        chk("t4_err",  256'(err_overflow), 256'(1));
        psum_out_ready = 1'b1;
        @(negedge clk);
        chk("t4_valid_drop", 256'(psum_out_valid), 256'(0));
        chk("t4_err_sticky", 256'(err_overflow), 256'(1));
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("t4_err_clr", 256'(err_overflow), 256'(0));

        // fc mode ignores precision: raw taps
        cfg(2'b00, 2'b01, 8'd1);
        beats(tp(1, 2, 3, 4, 5, 6, 7, 8), 1);
        @(negedge clk);
        chk("t5_fc_data", psum_out_data, ln(1, 2, 3, 4, 5, 6, 7, 8));

        // preci 10: lane0 = (17<<8)+2, lane1 = (3<<8)+4
        cfg(2'b10, 2'b10, 8'd1);
        beats(tp(1, 2, 3, 4, 1, 0, 0, 0), 1);
        @(negedge clk);
        chk("t6_p10_data", psum_out_data, ln(4354, 772, 0, 0, 0, 0, 0, 0));

        // clr with a concurrent beat drops the partial group and that beat
        cfg(2'b01, 2'b00, 8'd2);
        beats(tp(3, 0, 0, 0, 0, 0, 0, 0), 1);
        clr = 1'b1;
        beats(tp(100, 0, 0, 0, 0, 0, 0, 0), 1);
        clr = 1'b0;
        chk("t7_busy_clr", 256'(busy), 256'(0));
        mac_out_data = tp(10, 0, 0, 0, 0, 0, 0, 0); mac_out_valid = 1'b1;
        @(negedge clk);
        mac_out_data = tp(20, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        mac_out_valid = 1'b0;
        @(negedge clk);
        chk("t7_valid", 256'(psum_out_valid), 256'(1));
        chk("t7_data",  psum_out_data, ln(30, 0, 0, 0, 0, 0, 0, 0));

        // async reset mid-group with a held result
        psum_out_ready = 1'b0;
        cfg(2'b01, 2'b00, 8'd1);
        beats(tp(5, 0, 0, 0, 0, 0, 0, 0), 1);
        @(negedge clk);
        cfg(2'b01, 2'b00, 8'd4);
        beats(tp(1, 0, 0, 0, 0, 0, 0, 0), 2);
        rst = 1'b1;
        #1;
        chk("t8_rst_data",  psum_out_data, '0);
        chk("t8_rst_valid", 256'(psum_out_valid), 256'(0));
        chk("t8_rst_busy",  256'(busy), 256'(0));
        @(negedge clk);
        rst = 1'b0;
        psum_out_ready = 1'b1;
        beats(tp(1, 0, 0, 0, 0, 0, 0, 0), 4);
        chk("t8_valid_early", 256'(psum_out_valid), 256'(0));
        @(negedge clk);
        chk("t8_data", psum_out_data, ln(4, 0, 0, 0, 0, 0, 0, 0));

        // preci 11 overflow: 2 * 0x7FFF0000
`ifdef PSUM_SAT_EN
        sat_exp = 32'h7FFF_FFFF;
`else
        sat_exp = 32'hFFFE_0000;
`endif
        cfg(2'b01, 2'b11, 8'd2);
        beats(tp(16'h7FFF, 0, 0, 0, 0, 0, 0, 0), 2);
        @(negedge clk);
        chk("t9_sat_data", psum_out_data, ln(sat_exp, 0, 0, 0, 0, 0, 0, 0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
